// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline types: ID/EX payload bundle, skid-stage state
// encoding and ALU control codes.
package riscv_pipe_pkg;

  localparam int RV_DATA_WIDTH       = 32;
  localparam int RV_REG_ADDR_WIDTH   = 5;
  localparam int RV_ALU_CTRL_WIDTH   = 4;
  localparam int RV_RESULT_SRC_WIDTH = 2;

  // ALU control encoding (4 bits so SLT/SRA/SLTU fit alongside the basics)
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_SUB  = 4'b0001;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_AND  = 4'b0010;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_OR   = 4'b0011;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_XOR  = 4'b0100;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_SLT  = 4'b0101;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_SLL  = 4'b0110;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_SRL  = 4'b0111;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_SRA  = 4'b1000;
  localparam logic [RV_ALU_CTRL_WIDTH-1:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic [RV_DATA_WIDTH-1:0]       rd1;
    logic [RV_DATA_WIDTH-1:0]       rd2;
    logic [RV_DATA_WIDTH-1:0]       pc;
    logic [RV_DATA_WIDTH-1:0]       pc_plus4;
    logic [RV_DATA_WIDTH-1:0]       imm_ext;
    logic [RV_REG_ADDR_WIDTH-1:0]   rd;
    logic [RV_REG_ADDR_WIDTH-1:0]   rs1;
    logic [RV_REG_ADDR_WIDTH-1:0]   rs2;
    logic                           reg_write;
    logic [RV_RESULT_SRC_WIDTH-1:0] result_src;
    logic                           mem_write;
    logic                           jump;
    logic                           branch;
    logic [RV_ALU_CTRL_WIDTH-1:0]   alu_ctrl;
    logic                           alu_src;
  } id_ex_payload_t;

  // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } idex_state_e;

  // Kill the architectural side effects of a payload that is not valid.
  function automatic id_ex_payload_t mask_ctrl(input id_ex_payload_t p, input logic v);
    id_ex_payload_t r;
    r           = p;
    r.reg_write = p.reg_write & v;
    r.mem_write = p.mem_write & v;
    r.jump      = p.jump & v;
    r.branch    = p.branch & v;
    return r;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by rst.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// Elastic ID/EX stage with a 2-entry skid buffer. ready_d_o comes straight
// from a flop so decode never sees a combinational path from ready_e_i.
// Optional stall/bubble performance counters: define IDEX_PERF_CNT_EN.
module id_ex_skid_reg
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int ALU_CTRL_WIDTH   = 4,
  parameter int RESULT_SRC_WIDTH = 2,
  parameter int CNT_WIDTH        = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           valid_d_i,
  output logic           ready_d_o,
  input  id_ex_payload_t payload_d_i,
  output logic           valid_e_o,
  input  logic           ready_e_i,
  output id_ex_payload_t payload_e_o
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] bubble_cnt_o
`endif
);

  id_ex_payload_t main_q, main_d;
  id_ex_payload_t skid_q, skid_d;
  logic           main_v_q, main_v_d;
  logic           skid_v_q, skid_v_d;

  idex_state_e    state;
  logic           accept;
  logic           take;

  assign state     = idex_state_e'({main_v_q, skid_v_q});
  assign ready_d_o = ~skid_v_q;
  assign valid_e_o = main_v_q;
  assign accept    = valid_d_i & ready_d_o;
  assign take      = main_v_q & ready_e_i;

  // Next-state and payload steering; flush overrides every handshake event.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_d   = '0;
      skid_d   = '0;
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_d   = payload_d_i;
            main_v_d = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_d = payload_d_i;
          end else if (accept) begin
            skid_d   = payload_d_i;
            skid_v_d = 1'b1;
          end else if (take) begin
            main_v_d = 1'b0;
          end
        end
        FULL: begin
          // ready_d_o is low here, so only the drain side can move.
          if (take) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          // Unreachable skid-only state: recover to EMPTY.
          main_d   = '0;
          skid_d   = '0;
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // Stage registers with asynchronous clear of flags and payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  // Control bits are gated by valid so a stale payload cannot write or branch.
  always_comb begin
    payload_e_o = mask_ctrl(main_q, main_v_q);
  end

`ifdef IDEX_PERF_CNT_EN
  pipe_sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (main_v_q & ~ready_e_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.W(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~main_v_q),
    .cnt_o (bubble_cnt_o)
  );
`endif

  // The payload struct is sized by the package; instance widths must agree.
  a_widths_match : assert property (@(posedge clk)
    (DATA_WIDTH == RV_DATA_WIDTH) && (REG_ADDR_WIDTH == RV_REG_ADDR_WIDTH) &&
    (ALU_CTRL_WIDTH == RV_ALU_CTRL_WIDTH) && (RESULT_SRC_WIDTH == RV_RESULT_SRC_WIDTH) &&
    (CNT_WIDTH > 0));

  // A skid entry can never exist without a main entry ahead of it.
  a_no_skid_only : assert property (@(posedge clk) disable iff (rst)
    !(skid_v_q && !main_v_q));

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed + scoreboarded random bench for id_ex_skid_reg.
module tb_id_ex_skid_reg;
  import riscv_pipe_pkg::*;

  localparam int TB_CNT_W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush_i;
  logic           valid_d_i;
  logic           ready_d_o;
  id_ex_payload_t payload_d_i;
  logic           valid_e_o;
  logic           ready_e_i;
  id_ex_payload_t payload_e_o;
`ifdef IDEX_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt_o;
  logic [TB_CNT_W-1:0] bubble_cnt_o;
`endif

  int  checks   = 0;
  int  failures = 0;
  bit  log_en   = 1'b1;
  id_ex_payload_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_skid_reg #(.CNT_WIDTH(TB_CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .valid_d_i   (valid_d_i),
    .ready_d_o   (ready_d_o),
    .payload_d_i (payload_d_i),
    .valid_e_o   (valid_e_o),
    .ready_e_i   (ready_e_i),
    .payload_e_o (payload_e_o)
`ifdef IDEX_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic id_ex_payload_t mk(input logic [31:0] pc);
    id_ex_payload_t p;
    p            = '0;
    p.pc         = pc;
    p.pc_plus4   = pc + 32'd4;
    p.rd1        = pc ^ 32'hA5A5_0000;
    p.rd2        = ~pc;
    p.imm_ext    = pc << 1;
    p.rd         = pc[6:2];
    p.rs1        = pc[6:2] + 5'd1;
    p.rs2        = pc[6:2] + 5'd2;
    p.reg_write  = 1'b1;
    p.mem_write  = 1'b1;
    p.branch     = 1'b1;
    p.jump       = pc[3];
    p.result_src = 2'b01;
    p.alu_ctrl   = ALU_SLTU;
    p.alu_src    = 1'b1;
    return p;
  endfunction

  function automatic id_ex_payload_t rnd_payload();
    id_ex_payload_t p;
    p            = '0;
    p.rd1        = $urandom;
    p.rd2        = $urandom;
    p.pc         = $urandom;
    p.pc_plus4   = $urandom;
    p.imm_ext    = $urandom;
    p.rd         = 5'($urandom_range(0, 31));
    p.rs1        = 5'($urandom_range(0, 31));
    p.rs2        = 5'($urandom_range(0, 31));
    p.reg_write  = 1'($urandom_range(0, 1));
    p.result_src = 2'($urandom_range(0, 3));
    p.mem_write  = 1'($urandom_range(0, 1));
    p.jump       = 1'($urandom_range(0, 1));
    p.branch     = 1'($urandom_range(0, 1));
    p.alu_ctrl   = 4'($urandom_range(0, 9));
    p.alu_src    = 1'($urandom_range(0, 1));
    return p;
  endfunction

  // One line per beat handed to execute during the directed tests.
  always @(negedge clk) begin
    if (log_en && !rst && valid_e_o && ready_e_i)
      $display("txn take pc=%08h rd=%0d", payload_e_o.pc, payload_e_o.rd);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    flush_i     = 1'b0;
    valid_d_i   = 1'b0;
    ready_e_i   = 1'b0;
    payload_d_i = '0;
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_valid", 192'(valid_e_o), 192'(1'b0));
    chk("rst_ready", 192'(ready_d_o), 192'(1'b1));
    chk("rst_payload", 192'(payload_e_o), 192'(0));
    rst = 1'b0;

    // Streaming at full rate.
    ready_e_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_d_i   = 1'b1;
      payload_d_i = mk(32'(4 * i));
      step();
      chk("stream_valid", 192'(valid_e_o), 192'(1'b1));
      chk("stream_pc", 192'(payload_e_o.pc), 192'(4 * i));
      chk("stream_ready", 192'(ready_d_o), 192'(1'b1));
    end
    valid_d_i = 1'b0;
    step();
    chk("drain_valid", 192'(valid_e_o), 192'(1'b0));
    chk("mask_branch", 192'(payload_e_o.branch), 192'(1'b0));
    chk("mask_reg_write", 192'(payload_e_o.reg_write), 192'(1'b0));
    chk("unmasked_pc", 192'(payload_e_o.pc), 192'(32'h1C));

    // Back-pressure into the skid entry.
    valid_d_i = 1'b1; payload_d_i = mk(32'h10); ready_e_i = 1'b1;
    step();
    chk("bp_main", 192'(payload_e_o.pc), 192'(32'h10));
    ready_e_i = 1'b0; payload_d_i = mk(32'h14);
    step();
    chk("bp_full_ready", 192'(ready_d_o), 192'(1'b0));
    chk("bp_full_pc", 192'(payload_e_o.pc), 192'(32'h10));
    payload_d_i = mk(32'h18);
    step();
    chk("bp_hold_ready", 192'(ready_d_o), 192'(1'b0));
    chk("bp_hold_pc", 192'(payload_e_o.pc), 192'(32'h10));
    valid_d_i = 1'b0;
    step();
    chk("bp_vdrop_pc", 192'(payload_e_o.pc), 192'(32'h10));
    chk("bp_vdrop_valid", 192'(valid_e_o), 192'(1'b1));
    valid_d_i = 1'b1; ready_e_i = 1'b1;
    step();
    chk("bp_out2_pc", 192'(payload_e_o.pc), 192'(32'h14));
    chk("bp_out2_ready", 192'(ready_d_o), 192'(1'b1));
    step();
    chk("bp_out3_pc", 192'(payload_e_o.pc), 192'(32'h18));
    chk("bp_out3_valid", 192'(valid_e_o), 192'(1'b1));
    valid_d_i = 1'b0;
    step();
    chk("bp_empty", 192'(valid_e_o), 192'(1'b0));

    // Flush while FULL with a new beat on offer.
    valid_d_i = 1'b1; payload_d_i = mk(32'h40); ready_e_i = 1'b1;
    step();
    ready_e_i = 1'b0; payload_d_i = mk(32'h44);
    step();
    chk("fl_pre_ready", 192'(ready_d_o), 192'(1'b0));
    flush_i = 1'b1; payload_d_i = mk(32'h48); ready_e_i = 1'b1;
    step();
    chk("fl_valid", 192'(valid_e_o), 192'(1'b0));
    chk("fl_reg_write", 192'(payload_e_o.reg_write), 192'(1'b0));
    chk("fl_mem_write", 192'(payload_e_o.mem_write), 192'(1'b0));
    chk("fl_ready", 192'(ready_d_o), 192'(1'b1));
    chk("fl_pc_zero", 192'(payload_e_o.pc), 192'(0));
    flush_i = 1'b0; valid_d_i = 1'b0;
    step();
    chk("fl_no_ghost", 192'(valid_e_o), 192'(1'b0));

    // Asynchronous reset between edges while FULL.
    valid_d_i = 1'b1; payload_d_i = mk(32'h50); ready_e_i = 1'b1;
    step();
    ready_e_i = 1'b0; payload_d_i = mk(32'h54);
    step();
    valid_d_i = 1'b0;
    chk("ar_pre_ready", 192'(ready_d_o), 192'(1'b0));
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 192'(valid_e_o), 192'(1'b0));
    chk("ar_payload", 192'(payload_e_o), 192'(0));
    chk("ar_ready", 192'(ready_d_o), 192'(1'b1));
    #1 rst = 1'b0;
    ready_e_i = 1'b1;
    step();
    chk("ar_after", 192'(valid_e_o), 192'(1'b0));

    // Random valid/ready/flush traffic against a queue scoreboard.
    log_en = 1'b0;
    sb_q.delete();
    for (int c = 0; c < 10000; c++) begin
      bit vd, re, fl, rdy;
      chk("rnd_valid", 192'(valid_e_o), 192'(sb_q.size() > 0));
      chk("rnd_ready", 192'(ready_d_o), 192'(sb_q.size() < 2));
      rdy = (sb_q.size() < 2);
      vd  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 31) == 0);
      valid_d_i   = vd;
      ready_e_i   = re;
      flush_i     = fl;
      payload_d_i = rnd_payload();
      if (fl) begin
        sb_q.delete();
      end else begin
        if (sb_q.size() > 0 && re) begin
          chk("rnd_beat", 192'(payload_e_o), 192'(sb_q[0]));
          void'(sb_q.pop_front());
        end
        if (rdy && vd) sb_q.push_back(payload_d_i);
      end
      step();
    end
    valid_d_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;

`ifdef IDEX_PERF_CNT_EN
    // Saturating stall counter and flush-immune counters.
    rst = 1'b1;
    #1;
    chk("pc_rst_stall", 192'(stall_cnt_o), 192'(0));
    chk("pc_rst_bubble", 192'(bubble_cnt_o), 192'(0));
    rst = 1'b0;
    valid_d_i = 1'b1; payload_d_i = mk(32'h60); ready_e_i = 1'b0;
    step();
    valid_d_i = 1'b0;
    chk("pc_bubble1", 192'(bubble_cnt_o), 192'(1));
    chk("pc_stall0", 192'(stall_cnt_o), 192'(0));
    for (int k = 0; k < 20; k++) step();
    chk("pc_stall_sat", 192'(stall_cnt_o), 192'(15));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("pc_flush_stall", 192'(stall_cnt_o), 192'(15));
    chk("pc_flush_bubble", 192'(bubble_cnt_o), 192'(1));
    step();
    chk("pc_bubble2", 192'(bubble_cnt_o), 192'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
